timer_counter_n: RTL

//  Parametrised successor of the 8-bit timer counter: WIDTH-bit up/down counter with

---
 rtl/timer_counter_n.sv | 111 +++++++++++
 1 files changed

// File: rtl/timer_counter_n.sv
// timer_counter_n: WIDTH-bit up/down timer with an internal power-of-two prescaler,
// auto-reload, one-shot mode and sticky overflow / underflow / compare-match flags.
// All state is updated on the rising edge of clk. Reset is synchronous and active-low.
module timer_counter_n #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] start_counter,
  input  logic [WIDTH-1:0] cmp_val,
  input  logic [SEL_W-1:0] clk_sel,
  input  logic             up_down,
  input  logic             load,
  input  logic             enable,
  input  logic             auto_reload,
  input  logic             one_shot,
  input  logic             clr_overflow,
  input  logic             clr_underflow,
  input  logic             clr_cmp,
  output logic [WIDTH-1:0] tcnt,
  output logic             overflow,
  output logic             underflow,
  output logic             cmp_match
);

  // The prescaler must be able to hold the largest terminal value 2^(2^SEL_W)-1.
  localparam int PSC_W = 1 << SEL_W;
  localparam logic [WIDTH-1:0] MAX = '1;

  logic [PSC_W-1:0] psc;
  logic             run;
  logic             active;
  logic             tick;
  logic [PSC_W:0]   one_hot;
  logic [PSC_W:0]   term_ext;
  logic [PSC_W-1:0] psc_term;
  logic [WIDTH-1:0] tcnt_nxt;
  logic             ovf_set;
  logic             udf_set;
  logic             cmp_set;

  // Terminal prescaler value 2^(clk_sel+1)-1; the select is widened so the top code does not wrap.
  assign one_hot  = {{PSC_W{1'b0}}, 1'b1} << ({1'b0, clk_sel} + 1'b1);
  assign term_ext = one_hot - {{PSC_W{1'b0}}, 1'b1};
  assign psc_term = term_ext[PSC_W-1:0];

  // A stopped one-shot freezes both the counter and the prescaler.
  assign active = ~one_shot | run;
  assign tick   = enable & active & (psc == psc_term);

  // Next count on a tick, including the wrap value and which wrap flag it raises.
  always_comb begin
    tcnt_nxt = tcnt;
    ovf_set  = 1'b0;
    udf_set  = 1'b0;
    if (up_down) begin
      if (tcnt == MAX) begin
        tcnt_nxt = auto_reload ? start_counter : '0;
        ovf_set  = 1'b1;
      end else begin
        tcnt_nxt = tcnt + 1'b1;
      end
    end else begin
      if (tcnt == '0) begin
        tcnt_nxt = auto_reload ? start_counter : MAX;
        udf_set  = 1'b1;
      end else begin
        tcnt_nxt = tcnt - 1'b1;
      end
    end
  end

  // A load masks every flag source, even when a tick lands on the same edge.
  assign cmp_set = tick & ~load & (tcnt_nxt == cmp_val);

  // Counter, prescaler and one-shot run state: reset > load > tick > prescale.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tcnt <= '0;
      psc  <= '0;
      run  <= 1'b0;
    end else if (load) begin
      tcnt <= start_counter;
      psc  <= '0;
      run  <= 1'b1;
    end else if (tick) begin
      tcnt <= tcnt_nxt;
      psc  <= '0;
      if (one_shot && (ovf_set || udf_set)) begin
        run <= 1'b0;
      end
    end else if (enable && active) begin
      psc <= psc + 1'b1;
    end
  end

  // Sticky status flags: a set on the same edge as a clear takes precedence.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
      cmp_match <= 1'b0;
    end else begin
      overflow  <= (tick & ~load & ovf_set) | (overflow  & ~clr_overflow);
      underflow <= (tick & ~load & udf_set) | (underflow & ~clr_underflow);
      cmp_match <= cmp_set | (cmp_match & ~clr_cmp);
    end
  end

endmodule
